// File: rtl/ppu_quant_ctrl.sv
// PPU output sequencer: quantizes signed partial sums to uint8 (shift, saturate, ReLU, +128)
// and packs four results per 32-bit word for the output buffer.
module ppu_quant_ctrl #(
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [5:0]           cfg_scale,
    input  logic                 cfg_relu,
    input  logic [LEN_BITS-1:0]  cfg_len,
    output logic                 busy,
    output logic                 done,
    input  logic                 psum_valid,
    input  logic [DATA_BITS-1:0] psum_data,
    output logic                 psum_ready,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    output logic [3:0]           out_strb,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LEN_BITS-1:0]         LEN_ONE = LEN_BITS'(1);
    localparam logic signed [DATA_BITS-1:0] SAT_MAX = DATA_BITS'(127);
    localparam logic signed [DATA_BITS-1:0] SAT_MIN = DATA_BITS'(-128);

    function automatic logic [7:0] quantize(input logic signed [DATA_BITS-1:0] x,
                                            input logic [5:0] sh,
                                            input logic relu);
        logic signed [DATA_BITS-1:0] s;
        logic signed [7:0]           q;
        s = x >>> sh;
        if (s > SAT_MAX)      q = 8'sd127;
        else if (s < SAT_MIN) q = -8'sd128;
        else                  q = s[7:0];
        if (relu && q[7]) q = 8'sd0;
        // Adding the 128 zero-point to an int8 just flips its sign bit.
        return {~q[7], q[6:0]};
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] l);
        case (l)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    logic [1:0]          state_q, state_d;
    logic [5:0]          scale_q, scale_d;
    logic                relu_q, relu_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] in_cnt_q, in_cnt_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         pack_q, pack_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [3:0]          out_strb_q, out_strb_d;
    logic                out_last_q, out_last_d;

    logic [7:0]  q_byte;
    logic [31:0] word_c;
    logic        ready_c;
    logic        last_el_c;

    assign q_byte = quantize(psum_data, scale_q, relu_q);

    always_comb begin
        state_d     = state_q;
        scale_d     = scale_q;
        relu_d      = relu_q;
        len_d       = len_q;
        in_cnt_d    = in_cnt_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        ready_c     = 1'b0;
        last_el_c   = (in_cnt_q == len_q - LEN_ONE);
        word_c      = pack_q | ({24'd0, q_byte} << {lane_q, 3'b000});

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    scale_d  = cfg_scale;
                    relu_d   = cfg_relu;
                    len_d    = cfg_len;
                    in_cnt_d = '0;
                    lane_d   = 2'd0;
                    pack_d   = '0;
                    state_d  = (cfg_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // Stall input while a finished word is parked in the output register.
                ready_c = (in_cnt_q < len_q) && (!out_valid_q || out_ready);
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (psum_valid && ready_c) begin
                    in_cnt_d = in_cnt_q + LEN_ONE;
                    if (lane_q == 2'd3 || last_el_c) begin
                        out_data_d  = word_c;
                        out_strb_d  = lane_mask(lane_q);
                        out_last_d  = last_el_c;
                        out_valid_d = 1'b1;
                        lane_d      = 2'd0;
                        pack_d      = '0;
                    end else begin
                        pack_d = word_c;
                        lane_d = lane_q + 2'd1;
                    end
                    if (last_el_c) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            scale_q     <= '0;
            relu_q      <= 1'b0;
            len_q       <= '0;
            in_cnt_q    <= '0;
            lane_q      <= 2'd0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            scale_q     <= scale_d;
            relu_q      <= relu_d;
            len_q       <= len_d;
            in_cnt_q    <= in_cnt_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign psum_ready = ready_c;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_strb   = out_strb_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_ppu_quant_ctrl.sv
// Bench for ppu_quant_ctrl: directed tiles plus randomized tiles against a
// plain-arithmetic quantize/pack reference.
module tb_ppu_quant_ctrl;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [5:0]    cfg_scale = '0;
    logic          cfg_relu = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          psum_valid = 1'b0;
    logic [DW-1:0] psum_data = '0;
    logic          out_ready = 1'b0;
    logic          busy, done, psum_ready, out_valid, out_last;
    logic [31:0]   out_data;
    logic [3:0]    out_strb;

    int tests = 0;
    int fails = 0;
    int          psq[$];
    logic [36:0] got[$];

    ppu_quant_ctrl #(.DATA_BITS(DW), .LEN_BITS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_scale(cfg_scale), .cfg_relu(cfg_relu), .cfg_len(cfg_len),
        .busy(busy), .done(done),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(psum_ready),
        .out_valid(out_valid), .out_data(out_data), .out_strb(out_strb), .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference quantizer: floor division by 2^sc, clamp, ReLU, zero-point.
    function automatic logic [7:0] ref_byte(input int x, input int sc, input bit relu);
        longint s;
        s = longint'(x) >>> sc;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        if (relu && s < 0) s = 0;
        return 8'(s + 128);
    endfunction

    task automatic fill_random(input int len, input int sc);
        psq.delete();
        for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 2))
                0:       psq.push_back(int'($urandom));
                1:       psq.push_back($urandom_range(0, 4000) - 2000);
                default: psq.push_back((int'($urandom_range(0, 300)) - 150) <<< (sc > 24 ? 24 : sc));
            endcase
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_psum_ready"}, psum_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_strb"}, out_strb, 0);
    endtask

    task automatic run_tile(input int len, input int sc, input bit relu, input int rdy_pct,
                            input int vld_pct, input bit stall_mode, input bit poke, input string tag);
        int          idx = 0;
        int          ndone = 0;
        int          cyc = 0;
        int          stall_cnt = 5;
        int          nw;
        bit          seen = 0;
        bit          held = 0;
        bit          poked = 0;
        logic [36:0] held_w = '0;
        logic [31:0] ed;
        logic [3:0]  es;
        got.delete();
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_len = LW'(len); cfg_scale = 6'(sc); cfg_relu = relu;
        psum_valid = 1'b0; out_ready = 1'b1;
        while (ndone == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            cfg_start = 1'b0;
            if (poke && !poked && idx == 2) begin
                cfg_start = 1'b1; cfg_len = LW'(1); cfg_scale = 6'd0; cfg_relu = !relu;
                poked = 1;
            end
            if (idx < len) begin
                psum_valid = ($urandom_range(0, 99) < vld_pct);
                psum_data  = psq[idx];
            end else begin
                psum_valid = $urandom_range(0, 1);
                psum_data  = $urandom;
            end
            if (stall_mode && (!seen || stall_cnt > 0)) begin
                out_ready = 1'b0;
                if (seen) stall_cnt--;
            end else begin
                out_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            @(negedge clk);
            if (held) begin
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_word"}, {out_last, out_strb, out_data}, held_w);
            end
            held   = out_valid && !out_ready;
            held_w = {out_last, out_strb, out_data};
            if (out_valid && !out_ready) chk({tag, "_stall_ready"}, psum_ready, 0);
            if (out_valid) seen = 1;
            if (idx >= len) chk({tag, "_accept_past_len"}, psum_valid && psum_ready, 0);
            else if (psum_valid && psum_ready) idx++;
            if (out_valid && out_ready) got.push_back({out_last, out_strb, out_data});
            if (done) begin
                ndone++;
                chk({tag, "_busy_at_done"}, busy, 1);
            end
        end
        chk({tag, "_done_seen"}, ndone, 1);
        chk({tag, "_accepted"}, idx, len);
        @(posedge clk); #1;
        psum_valid = 1'b0; out_ready = $urandom_range(0, 1);
        @(negedge clk);
        chk({tag, "_done_pulse_width"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_out_valid"}, out_valid, 0);
        nw = (len + 3) / 4;
        chk({tag, "_nwords"}, got.size(), nw);
        for (int w = 0; w < nw && w < got.size(); w++) begin
            ed = '0;
            es = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < len) begin
                    ed = ed | (32'(ref_byte(psq[4 * w + k], sc, relu)) << (8 * k));
                    es[k] = 1'b1;
                end
            end
            chk($sformatf("%s_w%0d_data", tag, w), got[w][31:0], ed);
            chk($sformatf("%s_w%0d_strb", tag, w), got[w][35:32], es);
            chk($sformatf("%s_w%0d_last", tag, w), got[w][36], (w == nw - 1));
        end
    endtask

    initial begin
        int idx;
        int cyc;
        int len;
        int sc;

        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        psq = '{2048, -4096, 160, -160};
        run_tile(4, 4, 0, 100, 100, 0, 0, "t1");
        if (got.size() > 0) chk("t1_word", got[0], {1'b1, 4'hF, 32'h768A00FF});

        psq = '{-40, 400};
        run_tile(2, 2, 0, 100, 100, 0, 0, "t2_norelu");
        if (got.size() > 0) chk("t2_norelu_word", got[0], {1'b1, 4'h3, 32'h0000E476});
        run_tile(2, 2, 1, 100, 100, 0, 0, "t2_relu");
        if (got.size() > 0) chk("t2_relu_word", got[0], {1'b1, 4'h3, 32'h0000E480});

        psq = '{0, 0, 0, 0, 0, 0};
        run_tile(6, 0, 0, 100, 100, 0, 0, "t3");
        if (got.size() > 1) begin
            chk("t3_word0", got[0], {1'b0, 4'hF, 32'h80808080});
            chk("t3_word1", got[1], {1'b1, 4'h3, 32'h00008080});
        end

        fill_random(8, 8);
        run_tile(8, 8, 0, 100, 100, 1, 0, "t4_stall");

        psq.delete();
        run_tile(0, 3, 0, 100, 100, 0, 0, "t5_len0");

        fill_random(12, 6);
        run_tile(12, 6, 1, 70, 90, 0, 1, "t5_poke");

        fill_random(8, 5);
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_len = LW'(8); cfg_scale = 6'd5; cfg_relu = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b0; out_ready = 1'b1; psum_valid = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 3 && cyc < 50) begin
            psum_data = psq[idx];
            @(negedge clk);
            if (psum_valid && psum_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6_pre_accepted", idx, 3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_abort");
        psum_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_reset", busy, 0);
        fill_random(8, 5);
        run_tile(8, 5, 0, 100, 100, 0, 0, "t6_restart");

        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 23);
            sc  = (r == 0) ? 31 : (r == 1) ? 63 : $urandom_range(0, 40);
            fill_random(len, sc);
            run_tile(len, sc, $urandom_range(0, 1), $urandom_range(40, 100),
                     $urandom_range(50, 100), 0, 0, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ppu_quant_ctrl.md
Name: ppu_quant_ctrl

Overview:
Sequencer for the PPU output path. It takes a stream of signed partial sums and quantizes each one to uint8 using a per-layer arithmetic shift, saturation to the int8 range, optional ReLU and a +128 zero-point. It packs four results per 32-bit word and drives them to the output buffer under a valid/ready handshake. It runs one layer tile per start command and signals completion.

Parameters:
DATA_BITS, 32, width of incoming partial sums (two's complement)
LEN_BITS, 16, width of the element-count configuration

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_start  input  1  one-cycle start pulse; accepted only in IDLE
cfg_scale  input  6  right-shift amount, latched at start
cfg_relu  input  1  ReLU enable, latched at start
cfg_len  input  LEN_BITS  number of psums in the tile, latched at start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the tile is complete
psum_valid  input  1  psum stream valid
psum_data  input  DATA_BITS  signed partial sum
psum_ready  output  1  psum stream ready
out_valid  output  1  packed word valid
out_data  output  32  packed uint8 results; element k of a word is in byte k (byte 0 = bits 7:0)
out_strb  output  4  byte enables for the filled lanes
out_last  output  1  high on the word that holds element cfg_len-1
out_ready  input  1  downstream ready

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, psum_ready, out_valid, out_last are 0; out_data=0, out_strb=0; counters, lane index and pack register are cleared. Reset asserted mid-tile aborts the tile. No done is generated for an aborted tile.
- Quantization is combinational on psum_data:
  - s = $signed(psum_data) >>> scale.
  - q = s clamped to [-128, 127].
  - If relu is set and q<0, q=0.
  - byte = q + 128, an 8-bit unsigned value.
  - scale up to 63 is legal. With DATA_BITS=32, any scale of 31 or more yields s = 0 or -1.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on cfg_start, latch scale, relu and len; clear in_cnt and lane. Go to RUN if len!=0, else go to DONE.
  - RUN: psum_ready = (in_cnt<len) && (!out_valid || out_ready). An input is accepted when psum_valid && psum_ready.
  - On accept: write byte into pack lane[lane], then lane++ and in_cnt++.
  - If lane==3 or in_cnt==len-1 at accept, the pack register plus the current byte transfer to the output register at the same edge:
    - out_valid=1 on the next cycle.
    - out_strb = lanes filled; unfilled bytes are 0.
    - out_last=1 if this was element len-1.
    - lane resets to 0.
  - When the final element is accepted, go to DRAIN.
  - DRAIN: psum_ready=0. On the out_valid && out_ready handshake of the last word, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: 1 cycle from acceptance of the word-completing psum to out_valid.
- Output register: out_data, out_strb and out_last hold stable while out_valid && !out_ready.
  - If out_ready and a new word completes in the same cycle, the register reloads and out_valid stays 1, so back-to-back words are possible.
  - If out_ready with no completion, out_valid clears.
- Input stalls when the output register is occupied and not draining, so no word is ever dropped or overwritten.
- cfg_start outside IDLE is ignored, and the config registers are unchanged.
- psum_valid outside RUN is ignored; no state change.
- out_last is 0 on every word except the final one. busy is 1 from the cycle after an accepted start through the DONE cycle.

Test Plan:
1. scale=4, relu=0, len=4, psums {2048, -4096, 160, -160}, out_ready=1. Required: one word, bytes {0xFF, 0x00, 0x8A, 0x76}, out_data=0x768A00FF, strb=0xF, last=1, then a done pulse.
2. scale=2, psum=-40: relu=0 gives byte 0x76; relu=1 gives byte 0x80. Positive 400>>2=100 gives 0xE4 in both modes.
3. len=6, all psums 0, scale=0: word0 = 0x80808080 with strb 0xF and last=0; word1 = 0x00008080 with strb 0x3 and last=1; done after the word1 handshake.
4. len=8, continuous psum_valid, out_ready held 0 for 5 cycles after the first word. Required: psum_ready drops, word0 is held stable, and no data is lost. After release, word1 follows and both words match the reference model.
5. len=0 start: busy for one cycle (DONE), done pulse, no out_valid. A cfg_start pulsed mid-RUN has no effect.
6. Assert rst_n=0 after 3 of 8 elements are accepted. Required: all outputs 0 immediately and IDLE state. A new start then runs a full tile correctly, with lane 0 filled first.
